// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM arbiter.
//   state_t  : arbiter FSM states
//   port_t   : which requester owns the access in flight
//   cnt_width: width of the access cycle counter
package sram_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 20;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;
   typedef enum logic {PORT_VGA, PORT_HOST} port_t;

   // Counter must hold values 0 .. max(rd, wr).
   function automatic int unsigned cnt_width(input int unsigned rd, input int unsigned wr);
      int unsigned m;
      m = (rd > wr) ? rd : wr;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sram_pin_drv.sv
// Registered SRAM pin driver.
//   clk, rst            : clock, asynchronous active-high reset
//   ld                  : load address and write data for a new access
//   ld_addr, ld_wdata   : values loaded when ld is high
//   *_n_d, dq_oe_d      : next values of the strobes and the DQ output enable
//   cap_en              : capture SRAM_DQ into cap_data at this edge
//   cap_data            : last captured read word
//   SRAM_*              : SRAM pins; all outputs registered, DQ tristated unless writing
module sram_pin_drv
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              ce_n_d,
   input  logic              oe_n_d,
   input  logic              we_n_d,
   input  logic              lb_n_d,
   input  logic              ub_n_d,
   input  logic              dq_oe_d,
   input  logic              cap_en,
   output logic [DATA_W-1:0] cap_data,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_UB_N
);

   logic              dq_oe_q;
   logic [DATA_W-1:0] dq_out_q;

   assign SRAM_DQ = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         SRAM_ADDR <= '0;
         SRAM_CE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_WE_N <= 1'b1;
         SRAM_LB_N <= 1'b1;
         SRAM_UB_N <= 1'b1;
         dq_oe_q   <= 1'b0;
         dq_out_q  <= '0;
         cap_data  <= '0;
      end else begin
         SRAM_CE_N <= ce_n_d;
         SRAM_OE_N <= oe_n_d;
         SRAM_WE_N <= we_n_d;
         SRAM_LB_N <= lb_n_d;
         SRAM_UB_N <= ub_n_d;
         dq_oe_q   <= dq_oe_d;
         if (ld) begin
            SRAM_ADDR <= ld_addr;
            dq_out_q  <= ld_wdata;
         end
         if (cap_en) begin
            cap_data <= SRAM_DQ;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for a single asynchronous 16-bit SRAM.
//   avm_clk, avm_rst        : clock, asynchronous active-high reset
//   vga_req/addr/gnt        : VGA read request, address, 1-cycle accept pulse
//   vga_rdata/rvalid        : VGA read result and its 1-cycle valid pulse
//   host_req/we/addr/wdata/be/gnt : host request (read or byte-masked write), accept pulse
//   host_rdata/rvalid       : host read result and its 1-cycle valid pulse
//   busy                    : an access is in progress
//   SRAM_*                  : SRAM pins (registered, strobes active-low)
// VGA wins contention until it has been granted VGA_STREAK_MAX times in a row while the host
// waited; the host then gets the next slot.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W         = DEF_ADDR_W,
   parameter int unsigned DATA_W         = DEF_DATA_W,
   parameter int unsigned RD_CYCLES      = 1,
   parameter int unsigned WR_CYCLES      = 1,
   parameter int unsigned VGA_STREAK_MAX = 8
) (
   input  logic              avm_clk,
   input  logic              avm_rst,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic [DATA_W-1:0] vga_rdata,
   output logic              vga_rvalid,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic [1:0]        host_be,
   output logic              host_gnt,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_rvalid,
   output logic              busy,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_UB_N
);

   localparam int unsigned CNT_W    = cnt_width(RD_CYCLES, WR_CYCLES);
   localparam int unsigned STREAK_W = $clog2(VGA_STREAK_MAX + 1);

   localparam logic [CNT_W-1:0]    RD_LAST    = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0]    WR_LAST    = CNT_W'(WR_CYCLES - 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VGA_STREAK_MAX);

   state_t              state_q;
   port_t               rd_port_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [STREAK_W-1:0] streak_q;
   logic [DATA_W-1:0]   vga_hold_q;
   logic [DATA_W-1:0]   host_hold_q;

   logic              pick_vga;
   logic              pick_host;
   logic              go;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic              rd_last;
   logic              wr_last;

   logic              ld;
   logic              ce_n_d;
   logic              oe_n_d;
   logic              we_n_d;
   logic              lb_n_d;
   logic              ub_n_d;
   logic              dq_oe_d;
   logic              cap_en;
   logic [DATA_W-1:0] cap_data;

   // Arbitration: only meaningful while IDLE.
   assign pick_vga  = vga_req && (!host_req || (streak_q < STREAK_MAX));
   assign pick_host = host_req && !pick_vga;
   assign go        = (state_q == IDLE) && (vga_req || host_req);
   assign win_we    = pick_host && host_we;
   assign win_addr  = pick_vga ? vga_addr : host_addr;
   assign rd_last   = (cnt_q == RD_LAST);
   assign wr_last   = (cnt_q == WR_LAST);

   assign busy = (state_q != IDLE);

   // Freshly captured data is presented in the rvalid cycle, then held per port.
   assign vga_rdata  = vga_rvalid  ? cap_data : vga_hold_q;
   assign host_rdata = host_rvalid ? cap_data : host_hold_q;

   // Next values for the registered SRAM pins.
   always_comb begin
      ld      = 1'b0;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      lb_n_d  = 1'b1;
      ub_n_d  = 1'b1;
      dq_oe_d = 1'b0;
      cap_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (go) begin
               ld     = 1'b1;
               ce_n_d = 1'b0;
               if (win_we) begin
                  we_n_d  = 1'b0;
                  lb_n_d  = ~host_be[0];
                  ub_n_d  = ~host_be[1];
                  dq_oe_d = 1'b1;
               end else begin
                  oe_n_d = 1'b0;
                  lb_n_d = 1'b0;
                  ub_n_d = 1'b0;
               end
            end
         end
         READ: begin
            if (rd_last) begin
               cap_en = 1'b1;
            end else begin
               ce_n_d = 1'b0;
               oe_n_d = 1'b0;
               lb_n_d = 1'b0;
               ub_n_d = 1'b0;
            end
         end
         WRITE: begin
            // Last write cycle releases WE_N; data and CE_N stay for the TURN hold cycle.
            ce_n_d  = 1'b0;
            we_n_d  = wr_last;
            lb_n_d  = SRAM_LB_N;
            ub_n_d  = SRAM_UB_N;
            dq_oe_d = 1'b1;
         end
         TURN: begin
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         state_q     <= IDLE;
         rd_port_q   <= PORT_VGA;
         cnt_q       <= '0;
         streak_q    <= '0;
         vga_gnt     <= 1'b0;
         host_gnt    <= 1'b0;
         vga_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         vga_hold_q  <= '0;
         host_hold_q <= '0;
      end else begin
         vga_gnt     <= 1'b0;
         host_gnt    <= 1'b0;
         vga_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         if (vga_rvalid) begin
            vga_hold_q <= cap_data;
         end
         if (host_rvalid) begin
            host_hold_q <= cap_data;
         end
         if (!host_req) begin
            streak_q <= '0;
         end
         case (state_q)
            IDLE: begin
               if (go) begin
                  cnt_q     <= '0;
                  rd_port_q <= pick_vga ? PORT_VGA : PORT_HOST;
                  vga_gnt   <= pick_vga;
                  host_gnt  <= pick_host;
                  state_q   <= win_we ? WRITE : READ;
                  if (pick_host) begin
                     streak_q <= '0;
                  end else if (host_req && (streak_q < STREAK_MAX)) begin
                     streak_q <= streak_q + 1'b1;
                  end
               end
            end
            READ: begin
               if (rd_last) begin
                  state_q <= IDLE;
                  if (rd_port_q == PORT_VGA) begin
                     vga_rvalid <= 1'b1;
                  end else begin
                     host_rvalid <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WRITE: begin
               if (wr_last) begin
                  state_q <= TURN;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            TURN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   sram_pin_drv #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pin_drv (
      .clk       (avm_clk),
      .rst       (avm_rst),
      .ld        (ld),
      .ld_addr   (win_addr),
      .ld_wdata  (host_wdata),
      .ce_n_d    (ce_n_d),
      .oe_n_d    (oe_n_d),
      .we_n_d    (we_n_d),
      .lb_n_d    (lb_n_d),
      .ub_n_d    (ub_n_d),
      .dq_oe_d   (dq_oe_d),
      .cap_en    (cap_en),
      .cap_data  (cap_data),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ   (SRAM_DQ),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_LB_N (SRAM_LB_N),
      .SRAM_UB_N (SRAM_UB_N)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM on the pins, reference memory and
// per-port expected-data queues filled when requests are issued.
module tb_sram_arbiter;

   localparam int RD   = 1;
   localparam int SMAX = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        vga_req;
   logic [19:0] vga_addr;
   logic        vga_gnt;
   logic [15:0] vga_rdata;
   logic        vga_rvalid;
   logic        host_req;
   logic        host_we;
   logic [19:0] host_addr;
   logic [15:0] host_wdata;
   logic [1:0]  host_be;
   logic        host_gnt;
   logic [15:0] host_rdata;
   logic        host_rvalid;
   logic        busy;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        ce_n, oe_n, we_n, lb_n, ub_n;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int vga_gnt_n = 0, host_gnt_n = 0, vga_rv_n = 0, host_rv_n = 0;
   int dual_gnt_n = 0, oe_drive_n = 0, we_oe_n = 0;

   logic [15:0] sram    [0:1048575];
   logic [15:0] ref_mem [0:1048575];
   logic [15:0] mdl_rd;
   logic [15:0] vga_exp_q[$];
   logic [15:0] host_exp_q[$];

   sram_arbiter #(
      .ADDR_W         (20),
      .DATA_W         (16),
      .RD_CYCLES      (RD),
      .WR_CYCLES      (1),
      .VGA_STREAK_MAX (SMAX)
   ) dut (
      .avm_clk     (clk),
      .avm_rst     (rst),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .vga_gnt     (vga_gnt),
      .vga_rdata   (vga_rdata),
      .vga_rvalid  (vga_rvalid),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_be     (host_be),
      .host_gnt    (host_gnt),
      .host_rdata  (host_rdata),
      .host_rvalid (host_rvalid),
      .busy        (busy),
      .SRAM_ADDR   (sram_addr),
      .SRAM_DQ     (sram_dq),
      .SRAM_CE_N   (ce_n),
      .SRAM_OE_N   (oe_n),
      .SRAM_WE_N   (we_n),
      .SRAM_LB_N   (lb_n),
      .SRAM_UB_N   (ub_n)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] init_val(input logic [19:0] a);
      return a[15:0] ^ {a[19:16], 12'h5A3};
   endfunction

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                         input logic [1:0] be);
      return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
   endfunction

   // Behavioural SRAM: drives DQ during an enabled read, writes enabled lanes while WE_N is low.
   assign sram_dq = (!ce_n && !oe_n && we_n) ? mdl_rd : 16'hzzzz;

   always @(negedge clk) begin
      mdl_rd <= sram[sram_addr];
      if (!ce_n && !we_n) sram[sram_addr] <= merge(sram[sram_addr], sram_dq, ~{ub_n, lb_n});
   end

   // Event counters and bus-safety monitors.
   always @(negedge clk) begin
      if (vga_gnt) vga_gnt_n <= vga_gnt_n + 1;
      if (host_gnt) host_gnt_n <= host_gnt_n + 1;
      if (vga_rvalid) vga_rv_n <= vga_rv_n + 1;
      if (host_rvalid) host_rv_n <= host_rv_n + 1;
      if (vga_gnt && host_gnt) dual_gnt_n <= dual_gnt_n + 1;
      if (!oe_n && dut.u_pin_drv.dq_oe_q) oe_drive_n <= oe_drive_n + 1;
      if (!oe_n && !we_n) we_oe_n <= we_oe_n + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time=%0t limit=1000000", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one host request and wait for its grant; returns the grant cycle.
   task automatic host_issue(input logic we, input logic [19:0] a, input logic [15:0] d,
                             input logic [1:0] be, output bit ok, output int gcyc);
      host_we = we; host_addr = a; host_wdata = d; host_be = be; host_req = 1'b1;
      if (we) ref_mem[a] = merge(ref_mem[a], d, be);
      else host_exp_q.push_back(ref_mem[a]);
      ok = 1'b0; gcyc = -1;
      for (int i = 0; i < 50 && !ok; i++) begin
         tick();
         if (host_gnt) begin ok = 1'b1; gcyc = cyc; end
      end
      host_req = 1'b0;
   endtask

   task automatic host_wait_rv(output bit ok, output int rcyc);
      ok = 1'b0; rcyc = -1;
      for (int i = 0; i < 50 && !ok; i++) begin
         tick();
         if (host_rvalid) begin ok = 1'b1; rcyc = cyc; end
      end
   endtask

   task automatic test_reset();
      vga_req = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
      checks++; if ({vga_gnt, host_gnt, vga_rvalid, host_rvalid} !== 4'b0) begin
         failures++; $display("FAIL reset_pulses got=%b want=0000", {vga_gnt, host_gnt, vga_rvalid, host_rvalid});
      end
      checks++; if ({vga_rdata, host_rdata} !== 32'h0) begin
         failures++; $display("FAIL reset_rdata got=%h want=00000000", {vga_rdata, host_rdata});
      end
      checks++; if (sram_addr !== 20'h0) begin failures++; $display("FAIL reset_addr got=%h want=00000", sram_addr); end
      checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin
         failures++; $display("FAIL reset_strobes got=%b want=11111", {ce_n, oe_n, we_n, lb_n, ub_n});
      end
      checks++; if (dut.u_pin_drv.dq_oe_q !== 1'b0) begin
         failures++; $display("FAIL reset_dq_z got=%0b want=0", dut.u_pin_drv.dq_oe_q);
      end
      vga_req = 1'b0;
      rst = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset_mid_write();
      bit ok;
      int g0, r0;
      host_we = 1'b1; host_addr = 20'h00777; host_wdata = 16'h5A5A; host_be = 2'b11; host_req = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin tick(); if (host_gnt) ok = 1'b1; end
      host_req = 1'b0;
      checks++; if (!ok || we_n !== 1'b0) begin
         failures++; $display("FAIL midwr_we_low got_gnt=%0b we_n=%0b want gnt=1 we_n=0", ok, we_n);
      end
      #1 rst = 1'b1;
      #1;
      checks++; if ({we_n, ce_n} !== 2'b11) begin
         failures++; $display("FAIL midwr_strobes got=%b want=11", {we_n, ce_n});
      end
      checks++; if (dut.u_pin_drv.dq_oe_q !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL midwr_dq_busy got dq_oe=%0b busy=%0b want 0 0", dut.u_pin_drv.dq_oe_q, busy);
      end
      tick();
      rst = 1'b0;
      g0 = vga_gnt_n + host_gnt_n; r0 = vga_rv_n + host_rv_n;
      repeat (6) tick();
      checks++; if (vga_gnt_n + host_gnt_n - g0 != 0 || vga_rv_n + host_rv_n - r0 != 0) begin
         failures++; $display("FAIL midwr_quiet got gnts=%0d rvalids=%0d want 0 0",
                              vga_gnt_n + host_gnt_n - g0, vga_rv_n + host_rv_n - r0);
      end
   endtask

   task automatic host_read_check(input string name, input logic [19:0] a);
      bit ok, rok;
      int g, rc;
      logic [15:0] exp;
      host_issue(1'b0, a, 16'h0, 2'b11, ok, g);
      host_wait_rv(rok, rc);
      checks++; if (!ok || !rok || rc != g + RD) begin
         failures++; $display("FAIL %s_latency got gnt=%0b rv=%0b gap=%0d want 1 1 %0d", name, ok, rok, rc - g, RD);
      end
      exp = (host_exp_q.size() > 0) ? host_exp_q.pop_front() : 16'hxxxx;
      checks++; if (host_rdata !== exp) begin
         failures++; $display("FAIL %s_data got=%h want=%h", name, host_rdata, exp);
      end
      tick();
      checks++; if (host_rdata !== exp) begin
         failures++; $display("FAIL %s_hold got=%h want=%h", name, host_rdata, exp);
      end
      repeat (2) tick();
   endtask

   task automatic test_write_read();
      bit ok;
      int g, g0, r0;
      g0 = host_gnt_n; r0 = host_rv_n;
      host_issue(1'b1, 20'h12345, 16'hBEEF, 2'b11, ok, g);
      repeat (4) tick();
      checks++; if (!ok || host_gnt_n - g0 != 1 || host_rv_n - r0 != 0) begin
         failures++; $display("FAIL write_gnt got ok=%0b gnts=%0d rvalids=%0d want 1 1 0",
                              ok, host_gnt_n - g0, host_rv_n - r0);
      end
      host_read_check("read_beef", 20'h12345);
   endtask

   task automatic test_byte_write();
      bit ok;
      int g;
      host_issue(1'b1, 20'h12345, 16'hAA55, 2'b01, ok, g);
      repeat (3) tick();
      host_read_check("be01", 20'h12345);
      host_issue(1'b1, 20'h12345, 16'h1234, 2'b00, ok, g);
      repeat (3) tick();
      host_read_check("be00", 20'h12345);
   endtask

   task automatic test_priority_streak();
      int seq[$];
      vga_addr = 20'h00100; host_we = 1'b0; host_addr = 20'h00200;
      vga_req = 1'b1; host_req = 1'b1;
      for (int i = 0; i < 300 && seq.size() < 27; i++) begin
         tick();
         if (vga_gnt) seq.push_back(0);
         if (host_gnt) seq.push_back(1);
      end
      vga_req = 1'b0; host_req = 1'b0;
      repeat (6) tick();
      checks++; if (seq.size() != 27) begin
         failures++; $display("FAIL streak_count got=%0d want=27", seq.size());
      end
      for (int k = 0; k < seq.size(); k++) begin
         checks++; if (seq[k] != ((k % (SMAX + 1) == SMAX) ? 1 : 0)) begin
            failures++; $display("FAIL streak_grant idx=%0d got=%0d want=%0d", k, seq[k],
                                 (k % (SMAX + 1) == SMAX) ? 1 : 0);
         end
      end
   endtask

   task automatic test_vga_stream();
      bit drv_timeout;
      drv_timeout = 1'b0;
      fork
         begin
            bit got;
            for (int n = 0; n < 640; n++) begin
               vga_addr = 20'h40000 + 20'(n);
               vga_req = 1'b1;
               vga_exp_q.push_back(ref_mem[vga_addr]);
               got = 1'b0;
               for (int i = 0; i < 50 && !got; i++) begin
                  tick();
                  if (vga_gnt) got = 1'b1;
               end
               if (!got) begin drv_timeout = 1'b1; break; end
            end
            vga_req = 1'b0;
         end
         begin
            bit ok;
            int rc, prev;
            logic [15:0] exp;
            prev = 0;
            for (int n = 0; n < 640; n++) begin
               ok = 1'b0; rc = -1;
               for (int i = 0; i < 60 && !ok; i++) begin
                  tick();
                  if (vga_rvalid) begin ok = 1'b1; rc = cyc; end
               end
               if (!ok) begin
                  checks++; failures++;
                  $display("FAIL stream_rvalid idx=%0d got=timeout want=rvalid", n);
                  break;
               end
               exp = (vga_exp_q.size() > 0) ? vga_exp_q.pop_front() : 16'hxxxx;
               checks++; if (vga_rdata !== exp) begin
                  failures++; $display("FAIL stream_data idx=%0d got=%h want=%h", n, vga_rdata, exp);
               end
               if (n > 0) begin
                  checks++; if (rc - prev != RD + 1) begin
                     failures++; $display("FAIL stream_period idx=%0d got=%0d want=%0d", n, rc - prev, RD + 1);
                  end
               end
               prev = rc;
            end
         end
      join
      checks++; if (drv_timeout) begin
         failures++; $display("FAIL stream_gnt got=timeout want=640 grants");
      end
      repeat (4) tick();
   endtask

   task automatic test_host_during_vga();
      bit ok;
      int vg, vr, hg, hr, v0, h0;
      logic [15:0] vexp, hexp;
      v0 = vga_rv_n; h0 = host_rv_n;
      vg = -1; vr = -1; hg = -1; hr = -1;
      vga_addr = 20'h00ABC; vga_req = 1'b1;
      vga_exp_q.push_back(ref_mem[20'h00ABC]);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin tick(); if (vga_gnt) begin ok = 1'b1; vg = cyc; end end
      vga_req = 1'b0;
      host_we = 1'b0; host_addr = 20'h12345; host_req = 1'b1;
      host_exp_q.push_back(ref_mem[20'h12345]);
      checks++; if (!ok || busy !== 1'b1) begin
         failures++; $display("FAIL hv_vga_busy got gnt=%0b busy=%0b want 1 1", ok, busy);
      end
      vexp = (vga_exp_q.size() > 0) ? vga_exp_q.pop_front() : 16'hxxxx;
      hexp = (host_exp_q.size() > 0) ? host_exp_q.pop_front() : 16'hxxxx;
      for (int i = 0; i < 20 && hr < 0; i++) begin
         tick();
         if (vga_rvalid) begin
            vr = cyc;
            checks++; if (vga_rdata !== vexp) begin
               failures++; $display("FAIL hv_vga_data got=%h want=%h", vga_rdata, vexp);
            end
         end
         if (host_gnt) begin hg = cyc; host_req = 1'b0; end
         if (host_rvalid) begin
            hr = cyc;
            checks++; if (host_rdata !== hexp) begin
               failures++; $display("FAIL hv_host_data got=%h want=%h", host_rdata, hexp);
            end
         end
      end
      host_req = 1'b0;
      checks++; if (vr != vg + RD || hg != vg + RD + 1 || hr != hg + RD) begin
         failures++; $display("FAIL hv_timing got vr=%0d hg=%0d hr=%0d want %0d %0d %0d",
                              vr - vg, hg - vg, hr - vg, RD, RD + 1, 2 * RD + 1);
      end
      repeat (4) tick();
      checks++; if (vga_rv_n - v0 != 1 || host_rv_n - h0 != 1) begin
         failures++; $display("FAIL hv_rvalid_count got vga=%0d host=%0d want 1 1", vga_rv_n - v0, host_rv_n - h0);
      end
      checks++; if (vga_rdata !== vexp) begin
         failures++; $display("FAIL hv_vga_hold got=%h want=%h", vga_rdata, vexp);
      end
   endtask

   task automatic test_bus_safety();
      checks++; if (oe_drive_n != 0) begin
         failures++; $display("FAIL dq_during_oe got=%0d want=0", oe_drive_n);
      end
      checks++; if (dual_gnt_n != 0) begin
         failures++; $display("FAIL dual_gnt got=%0d want=0", dual_gnt_n);
      end
      checks++; if (we_oe_n != 0) begin
         failures++; $display("FAIL we_oe_overlap got=%0d want=0", we_oe_n);
      end
   endtask

   initial begin
      for (int i = 0; i < 1048576; i++) begin
         sram[i]    = init_val(20'(i));
         ref_mem[i] = init_val(20'(i));
      end
      rst = 1'b1;
      vga_req = 1'b0; vga_addr = '0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_be = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_reset_mid_write();
      test_write_read();
      test_byte_write();
      test_priority_streak();
      test_vga_stream();
      test_host_during_vga();
      test_bus_safety();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
